tdm_mux8: RTL and testbench

// - 8:1 time-shared multiplexer with valid/ready handshakes; collects beats from 8 input

---
 rtl/tdm_mux_pkg.sv | 18 +
 rtl/tdm_mux8_rr_arbiter8.sv | 44 ++++
 rtl/tdm_mux8.sv | 110 +++++++++++
 tb/tb_tdm_mux8.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the 8:1 TDM multiplexer: channel count, select width,
// output-register state encoding and the wrapping pointer increment.
package tdm_mux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Modulo-8 increment; the 3-bit width provides the 7 -> 0 wrap.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
        return ptr + SEL_W'(1);
    endfunction

endpackage

// File: rtl/tdm_mux8_rr_arbiter8.sv
// Rotating-priority arbiter for 8 requesters: the lowest index at or after ptr
// wins, wrapping 7 -> 0. Produces a one-hot grant plus its encoded index.
module rr_arbiter8
    import tdm_mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [N_CH-1:0]  rot;
    logic [SEL_W-1:0] off;

    // Rotate requests so that bit 0 corresponds to the channel at ptr.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
            logic [SEL_W-1:0] idx;
            assign idx     = ptr + SEL_W'(gi);
            assign rot[gi] = req[idx];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign gnt_vld = en & (|req);
    assign gnt_idx = ptr + off;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_gnt
            assign gnt[gi] = gnt_vld & (gnt_idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/tdm_mux8.sv
// 8:1 time-shared mux with valid/ready handshakes and a registered, channel-tagged
// output. Define TDM_MUX_FIXED_SLOT_EN for strict slot-per-cycle TDM instead of round-robin.
module tdm_mux8
    import tdm_mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    output logic [DW-1:0]        out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    out_state_t       state_reg, state_next;
    logic [DW-1:0]    data_reg;
    logic [SEL_W-1:0] sel_reg;

    logic             can_load;
    logic [N_CH-1:0]  arb_req;
    logic [SEL_W-1:0] arb_ptr;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [DW-1:0]    chan_data [N_CH];
    logic [DW-1:0]    gnt_data;

`ifdef TDM_MUX_FIXED_SLOT_EN
    // Only the channel owning the current slot may request; the slot free-runs.
    logic [SEL_W-1:0] slot_reg;

    assign arb_req = in_valid & (N_CH'(1) << slot_reg);
    assign arb_ptr = slot_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= rr_next(slot_reg);
        end
    end
`else
    logic [SEL_W-1:0] ptr_reg;

    assign arb_req = in_valid;
    assign arb_ptr = ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (gnt_vld) begin
            ptr_reg <= rr_next(gnt_idx);
        end
    end
`endif

    // The output register can take a beat if it is empty or draining this cycle.
    assign can_load = (state_reg == EMPTY) | out_ready;

    rr_arbiter8 u_arb (
        .req     (arb_req),
        .ptr     (arb_ptr),
        .en      (can_load & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign in_ready = gnt;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*DW +: DW];
        end
    endgenerate

    assign gnt_data = chan_data[gnt_idx];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (gnt_vld) state_next = FULL;
            FULL:  if (out_ready && !gnt_vld) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (gnt_vld) begin
                data_reg <= gnt_data;
                sel_reg  <= gnt_idx;
            end
        end
    end

    assign out_data  = data_reg;
    assign out_sel   = sel_reg;
    assign out_valid = (state_reg == FULL);

endmodule

// File: tb/tb_tdm_mux8.sv
// Scoreboard bench for tdm_mux8: the driver queues expected {sel,data} beats,
// a negedge monitor pops and compares each beat the DUT hands downstream.
module tb_tdm_mux8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    tdm_mux8 #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [7:0] dval(input int k);
        return 8'hA0 + 8'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: apply inputs, check the combinational grant, queue the expected beat.
    task automatic drive(input logic [7:0] vld, input logic ordy,
                         input logic [7:0] exp_rdy, input bit push);
        logic [2:0] sel;
        in_valid  = vld;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        sel = '0;
        for (int i = 0; i < 8; i++) if (exp_rdy[i]) sel = 3'(i);
        if (exp_rdy != 8'h00 && push) exp_q.push_back({sel, dval(int'(sel))});
        tick();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_sel", 32'(out_sel), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
        end
        rst      = 1'b0;
        in_valid = 8'h00;
    endtask

    task automatic drain();
        repeat (3) drive(8'h00, 1'b1, 8'h00, 1'b0);
    endtask

    // Monitor: every beat transferred downstream must match the queue head.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {21'h0, out_sel, out_data}, 32'h7FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_sel", 32'(out_sel), 32'(e[10:8]));
                    chk("beat_data", 32'(out_data), 32'(e[7:0]));
                    $display("beat sel=%0d data=%02h", out_sel, out_data);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = dval(k);
        rst       = 1'b1;
        in_valid  = 8'h00;
        out_ready = 1'b1;
        do_reset();

`ifdef TDM_MUX_FIXED_SLOT_EN
        begin
            logic [2:0] slot;
            slot = 3'd0;
            for (int c = 0; c < 20; c++) begin
                drive(8'h04, 1'b1, (slot == 3'd2) ? 8'h04 : 8'h00, 1'b1);
                slot = slot + 3'd1;
            end
            while (slot != 3'd2) begin
                drive(8'h04, 1'b1, 8'h00, 1'b1);
                slot = slot + 3'd1;
            end
            // Grant a beat with downstream stalled, then reset while it is held.
            drive(8'h04, 1'b0, 8'h04, 1'b0);
            chk("held_valid", 32'(out_valid), 32'h1);
            chk("held_sel", 32'(out_sel), 32'h2);
            chk("held_data", 32'(out_data), 32'(dval(2)));
            rst = 1'b1;
            #1;
            chk("midrst_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("midrst_out_valid", 32'(out_valid), 32'h0);
            rst  = 1'b0;
            slot = 3'd0;
            for (int c = 0; c < 12; c++) begin
                drive(8'h04, 1'b1, (slot == 3'd2) ? 8'h04 : 8'h00, 1'b1);
                slot = slot + 3'd1;
            end
            drain();
        end
`else
        // Single valid channel: one-cycle latency, granted every cycle.
        in_data[5*8 +: 8] = 8'hA5;
        drive(8'h20, 1'b1, 8'h20, 1'b1);
        chk("lat_out_valid", 32'(out_valid), 32'h1);
        chk("lat_out_sel", 32'(out_sel), 32'h5);
        chk("lat_out_data", 32'(out_data), 32'hA5);
        repeat (3) drive(8'h20, 1'b1, 8'h20, 1'b1);
        drain();

        // All channels valid: grants 0..7 then 0 with no gaps.
        do_reset();
        for (int k = 0; k < 9; k++) drive(8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1);
        drain();

        // Backpressure: ch3 held stable for 5 stalled cycles, then ch4 follows.
        do_reset();
        drive(8'h18, 1'b1, 8'h08, 1'b1);
        repeat (5) begin
            drive(8'h18, 1'b0, 8'h00, 1'b1);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_sel", 32'(out_sel), 32'h3);
            chk("bp_data", 32'(out_data), 32'(dval(3)));
        end
        drive(8'h18, 1'b1, 8'h10, 1'b1);
        drain();

        // Pointer wrap: after ch7, ch0 wins before ch7 again.
        do_reset();
        drive(8'h80, 1'b1, 8'h80, 1'b1);
        drive(8'h81, 1'b1, 8'h01, 1'b1);
        drive(8'h81, 1'b1, 8'h80, 1'b1);
        drive(8'h81, 1'b1, 8'h01, 1'b1);
        drain();
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
